// File: rtl/cpu5_ifu_pkg.sv
// Shared sizes, reset PC and queue-entry type for the cpu5 instruction fetch unit.
package cpu5_ifu_pkg;

    localparam int CPU5_PC_SIZE   = 32;
    localparam int CPU5_INST_SIZE = 32;
    localparam logic [CPU5_PC_SIZE-1:0] CPU5_PC_RESET = 32'h0000_0000;

    typedef struct packed {
        logic [CPU5_PC_SIZE-1:0]   pc;
        logic [CPU5_INST_SIZE-1:0] inst;
    } ifu_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [CPU5_PC_SIZE-1:0] align_pc(input logic [CPU5_PC_SIZE-1:0] addr);
        return addr & ~CPU5_PC_SIZE'(3);
    endfunction

endpackage

// File: rtl/cpu5_ifu_buf.sv
// Two-entry FIFO of {pc, inst} between the fetch handshake and decode.
module cpu5_ifu_buf
    import cpu5_ifu_pkg::*;
(
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic [CPU5_PC_SIZE-1:0]   push_pc,
    input  logic [CPU5_INST_SIZE-1:0] push_inst,
    input  logic                      pop,
    input  logic                      flush,
    output logic                      full,
    output logic                      empty,
    output logic [CPU5_PC_SIZE-1:0]   head_pc,
    output logic [CPU5_INST_SIZE-1:0] head_inst
);

    ifu_entry_t mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_pc   = mem[rd_ptr].pc;
    assign head_inst = mem[rd_ptr].inst;

    // Flush only rewinds the pointers; stale storage is never visible while empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{pc: push_pc, inst: push_inst};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/cpu5_ifu.sv
// cpu5 instruction fetch unit: fetch PC, credit-limited memory requests,
// in-flight response discard after redirects, and a 2-entry output queue.
module cpu5_ifu
    import cpu5_ifu_pkg::*;
#(
    parameter logic [CPU5_PC_SIZE-1:0] RESET_PC = CPU5_PC_RESET
)
(
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      redirect_valid,
    input  logic [CPU5_PC_SIZE-1:0]   redirect_pc,
    output logic                      imem_req,
    output logic [CPU5_PC_SIZE-1:0]   imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_rvalid,
    input  logic [CPU5_INST_SIZE-1:0] imem_rdata,
    output logic                      inst_valid,
    output logic [CPU5_INST_SIZE-1:0] inst,
    output logic [CPU5_PC_SIZE-1:0]   inst_pc,
    input  logic                      inst_ready
);

    logic [CPU5_PC_SIZE-1:0] fetch_pc;
    logic [CPU5_PC_SIZE-1:0] resp_pc;
    logic [CPU5_PC_SIZE-1:0] target;
    logic [1:0]              outstanding;
    logic [1:0]              discard;
    logic [1:0]              count;
    logic [2:0]              credit_used;
    logic                    full;
    logic                    empty;
    logic                    grant;
    logic                    rsp;
    logic                    push;
    logic                    pop;

    // Every request holds a queue slot, so the queue can never overflow.
    assign count       = {full, ~full & ~empty};
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign imem_req    = resetn & ~redirect_valid & (credit_used < 3'd2);
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req & imem_gnt;
    assign rsp         = imem_rvalid & (outstanding != 2'd0);
    assign push        = rsp & (discard == 2'd0) & ~redirect_valid;
    assign pop         = inst_valid & inst_ready & ~redirect_valid;
    assign target      = align_pc(redirect_pc);
    assign inst_valid  = ~empty;

    // A redirect orphans every request still in flight, minus one retiring now.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else if (redirect_valid) begin
            fetch_pc    <= target;
            resp_pc     <= target;
            outstanding <= outstanding - {1'b0, rsp};
            discard     <= outstanding - {1'b0, rsp};
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
            end
            outstanding <= outstanding + {1'b0, grant} - {1'b0, rsp};
            if (rsp && (discard != 2'd0)) begin
                discard <= discard - 2'd1;
            end
        end
    end

    cpu5_ifu_buf u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_pc   (resp_pc),
        .push_inst (imem_rdata),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (full),
        .empty     (empty),
        .head_pc   (inst_pc),
        .head_inst (inst)
    );

endmodule

// File: tb/tb_cpu5_ifu.sv
// Directed and randomized checks of cpu5_ifu against a queue-based fetch model
// with an in-order memory that answers grants after a random delay.
module tb_cpu5_ifu;
    import cpu5_ifu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int          tests = 0;
    int          fails = 0;
    int          dut_grants = 0;

    entry_t      mq[$];
    logic [31:0] pending[$];
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_resp = RESET_PC;
    int          m_out = 0;
    int          m_disc = 0;

    cpu5_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic exp_req();
        return !redirect_valid && ((m_out + mq.size()) < 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("imem_req", 32'(imem_req), 32'(exp_req()));
        chk("imem_addr", imem_addr, m_fetch);
        chk("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst", inst, mq[0].word);
        end
    endtask

    // One clock cycle: drive inputs, check pre-edge outputs, advance the model.
    task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic g,
                                 input logic rdy, input int rv_pct);
        logic   rv;
        logic   grant;
        logic   popq;
        entry_t e;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_gnt       = g;
        inst_ready     = rdy;
        rv             = (pending.size() > 0) && (int'($urandom_range(99)) < rv_pct);
        imem_rvalid    = rv;
        imem_rdata     = rv ? word_of(pending[0]) : $urandom();
        #2;
        checkOutput();
        if (imem_req && imem_gnt) dut_grants++;
        grant = exp_req() && g;
        popq  = rdy && (mq.size() > 0);
        @(posedge clk);
        if (rv) void'(pending.pop_front());
        if (grant) pending.push_back(m_fetch);
        if (rd) begin
            if (rv) m_out--;
            m_disc  = m_out;
            m_fetch = rpc & ~32'h3;
            m_resp  = m_fetch;
            mq.delete();
        end else begin
            if (grant) begin
                m_fetch += 4;
                m_out++;
            end
            if (popq) void'(mq.pop_front());
            if (rv) begin
                m_out--;
                if (m_disc > 0) begin
                    m_disc--;
                end else begin
                    e.pc   = m_resp;
                    e.word = imem_rdata;
                    mq.push_back(e);
                    m_resp += 4;
                end
            end
        end
        #1;
    endtask

    // Asserts reset between clock edges and checks the outputs clear at once.
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        inst_ready     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn     = 1'b1;
        m_fetch    = RESET_PC;
        m_resp     = RESET_PC;
        m_out      = 0;
        m_disc     = 0;
        dut_grants = 0;
        mq.delete();
        pending.delete();
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Streaming from reset with an always-ready memory and decode.
        do_reset();
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1, 100);
        chk("first_inst_valid", 32'(inst_valid), 32'd1);
        chk("first_inst_pc", inst_pc, 32'h0);
        repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b1, 100);

        // Decode back-pressure: only two requests may be granted.
        do_reset();
        repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0, 100);
        chk("bp_grants", 32'(dut_grants), 32'd2);
        chk("bp_req", 32'(imem_req), 32'd0);
        chk("bp_head_pc", inst_pc, 32'h0);
        repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b1, 100);

        // Redirect to an unaligned target with two requests in flight.
        do_reset();
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 0);
        applyStimulus(1'b1, 32'h0000_0103, 1'b1, 1'b0, 0);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0, 100);
        chk("redir_valid", 32'(inst_valid), 32'd1);
        chk("redir_pc", inst_pc, 32'h0000_0100);
        chk("redir_inst", inst, word_of(32'h0000_0100));

        // Redirect coinciding with a response and a pop.
        do_reset();
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1, 100);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1, 100);
        chk("flush_valid", 32'(inst_valid), 32'd0);
        repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b1, 100);

        // Grant stall at 0x8, then reset in the middle of it.
        do_reset();
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1, 100);
        repeat (7) applyStimulus(1'b0, '0, 1'b0, 1'b1, 100);
        chk("stall_req", 32'(imem_req), 32'd1);
        chk("stall_addr", imem_addr, 32'h0000_0008);
        do_reset();

        // Random traffic with occasional redirects.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(int'($urandom_range(99)) < 3, $urandom(),
                          int'($urandom_range(99)) < 70,
                          int'($urandom_range(99)) < 70, 60);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
